// File: rtl/id_ex_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_issue_pkg
// Purpose  : Shared widths, NOP encoding and issue-action decode for ID->EX.
// Revision : 1.0  initial release
// ============================================================================
package id_ex_issue_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int ALUOP_W = 6;
    localparam int CNT_W   = 16;

    localparam logic [ALUOP_W-1:0] c_ALUOP_NOP = 6'b0;

    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_BUBBLE = 2'd3
    } issue_act_e;

    // Flush beats hold beats load-use.
    function automatic issue_act_e issueAction(input logic flush, input logic hold,
                                               input logic loadUse);
        if (flush)        return ACT_FLUSH;
        else if (hold)    return ACT_HOLD;
        else if (loadUse) return ACT_BUBBLE;
        else              return ACT_NORMAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_issue_if
// Purpose  : ID-side inputs and EX-side outputs of the ID->EX issue register.
// Revision : 1.0  initial release
// ============================================================================
interface id_ex_issue_if #(
    parameter int DATA_W  = id_ex_issue_pkg::DATA_W,
    parameter int RADDR_W = id_ex_issue_pkg::RADDR_W,
    parameter int ALUOP_W = id_ex_issue_pkg::ALUOP_W,
    parameter int CNT_W   = id_ex_issue_pkg::CNT_W
);
    logic               RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID;
    logic               MemWrite_ID, RegDst_ID, ALUSrc_ID;
    logic [ALUOP_W-1:0] ALUOp_ID;
    logic [DATA_W-1:0]  PCAddResult_ID, ReadData1_ID, ReadData2_ID, SignExtResult_ID;
    logic [RADDR_W-1:0] rs_ID, rt_ID, rd_ID;
    logic               Valid_ID, Flush_MEM, Hold_MEM;

    logic               RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX;
    logic               MemWrite_EX, RegDst_EX, ALUSrc_EX;
    logic [ALUOP_W-1:0] ALUOp_EX;
    logic [DATA_W-1:0]  PCAddResult_EX, ReadData1_EX, ReadData2_EX, SignExtResult_EX;
    logic [RADDR_W-1:0] rs_EX, rt_EX, rd_EX;
    logic               Valid_EX, PCWrite, IFIDWrite;
    logic [CNT_W-1:0]   BubbleCount;

    modport master (
        output RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID,
               ALUSrc_ID, ALUOp_ID, PCAddResult_ID, ReadData1_ID, ReadData2_ID,
               SignExtResult_ID, rs_ID, rt_ID, rd_ID, Valid_ID, Flush_MEM, Hold_MEM,
        input  RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX,
               ALUSrc_EX, ALUOp_EX, PCAddResult_EX, ReadData1_EX, ReadData2_EX,
               SignExtResult_EX, rs_EX, rt_EX, rd_EX, Valid_EX, PCWrite, IFIDWrite,
               BubbleCount
    );

    modport slave (
        input  RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID,
               ALUSrc_ID, ALUOp_ID, PCAddResult_ID, ReadData1_ID, ReadData2_ID,
               SignExtResult_ID, rs_ID, rt_ID, rd_ID, Valid_ID, Flush_MEM, Hold_MEM,
        output RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX,
               ALUSrc_EX, ALUOp_EX, PCAddResult_EX, ReadData1_EX, ReadData2_EX,
               SignExtResult_EX, rs_EX, rt_EX, rd_EX, Valid_EX, PCWrite, IFIDWrite,
               BubbleCount
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_issue_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use hazard between the EX load and ID sources.
// Revision : 1.0  initial release
// ============================================================================
module load_use_detect #(
    parameter int RADDR_W = id_ex_issue_pkg::RADDR_W
) (
    input  wire logic               i_validEx,
    input  wire logic               i_memReadEx,
    input  wire logic               i_validId,
    input  wire logic [RADDR_W-1:0] i_rtEx,
    input  wire logic [RADDR_W-1:0] i_rsId,
    input  wire logic [RADDR_W-1:0] i_rtId,
    output logic                    o_loadUse
);
    logic w_srcMatch;

    // Register 0 is hardwired, so a load into it never creates a dependency.
    assign w_srcMatch = (i_rtEx == i_rsId) || (i_rtEx == i_rtId);
    assign o_loadUse  = i_validEx && i_memReadEx && i_validId &&
                        (i_rtEx != '0) && w_srcMatch;
endmodule
`default_nettype wire

// File: rtl/id_ex_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_issue
// Purpose  : ID->EX issue register with load-use stall, flush, hold and a
//            saturating bubble counter.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_issue #(
    parameter int DATA_W  = id_ex_issue_pkg::DATA_W,
    parameter int RADDR_W = id_ex_issue_pkg::RADDR_W,
    parameter int ALUOP_W = id_ex_issue_pkg::ALUOP_W,
    parameter int CNT_W   = id_ex_issue_pkg::CNT_W
) (
    input  wire logic    Clk,
    input  wire logic    Reset_n,
    id_ex_issue_if.slave bus
);
    import id_ex_issue_pkg::*;

    localparam int               c_CTRL_W  = 7 + ALUOP_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [c_CTRL_W-1:0] w_ctrlId;
    logic [c_CTRL_W-1:0] w_ctrlBubble;
    logic [c_CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0]   r_pcAdd, r_readData1, r_readData2, r_signExt;
    logic [RADDR_W-1:0]  r_rs, r_rt, r_rd;
    logic                r_valid;
    logic [CNT_W-1:0]    r_bubbleCount;
    logic [CNT_W-1:0]    w_bubbleInc;
    logic                w_loadUse;
    issue_act_e          w_act;

    load_use_detect #(.RADDR_W(RADDR_W)) u_loadUseDetect (
        .i_validEx   (r_valid),
        .i_memReadEx (bus.MemRead_EX),
        .i_validId   (bus.Valid_ID),
        .i_rtEx      (r_rt),
        .i_rsId      (bus.rs_ID),
        .i_rtId      (bus.rt_ID),
        .o_loadUse   (w_loadUse)
    );

    assign w_act = issueAction(bus.Flush_MEM, bus.Hold_MEM, w_loadUse);

    // An empty ID slot must never carry live control into EX.
    assign w_ctrlId = bus.Valid_ID ?
        {bus.RegWrite_ID, bus.MemtoReg_ID, bus.Branch_ID, bus.MemRead_ID,
         bus.MemWrite_ID, bus.RegDst_ID, bus.ALUSrc_ID, bus.ALUOp_ID} : '0;
    assign w_ctrlBubble = {7'b0, ALUOP_W'(c_ALUOP_NOP)};

    assign w_bubbleInc = (r_bubbleCount == c_CNT_MAX) ? r_bubbleCount
                                                      : r_bubbleCount + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ctrl        <= '0;
            r_valid       <= 1'b0;
            r_pcAdd       <= '0;
            r_readData1   <= '0;
            r_readData2   <= '0;
            r_signExt     <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_bubbleCount <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH: begin
                    r_ctrl        <= w_ctrlBubble;
                    r_valid       <= 1'b0;
                    r_pcAdd       <= bus.PCAddResult_ID;
                    r_readData1   <= bus.ReadData1_ID;
                    r_readData2   <= bus.ReadData2_ID;
                    r_signExt     <= bus.SignExtResult_ID;
                    r_rs          <= bus.rs_ID;
                    r_rt          <= bus.rt_ID;
                    r_rd          <= bus.rd_ID;
                    r_bubbleCount <= w_bubbleInc;
                end
                ACT_HOLD: begin
                    r_ctrl <= r_ctrl;
                end
                ACT_BUBBLE: begin
                    // Datapath keeps the load so the stalled consumer re-tests cleanly.
                    r_ctrl        <= w_ctrlBubble;
                    r_valid       <= 1'b0;
                    r_bubbleCount <= w_bubbleInc;
                end
                default: begin
                    r_ctrl      <= w_ctrlId;
                    r_valid     <= bus.Valid_ID;
                    r_pcAdd     <= bus.PCAddResult_ID;
                    r_readData1 <= bus.ReadData1_ID;
                    r_readData2 <= bus.ReadData2_ID;
                    r_signExt   <= bus.SignExtResult_ID;
                    r_rs        <= bus.rs_ID;
                    r_rt        <= bus.rt_ID;
                    r_rd        <= bus.rd_ID;
                end
            endcase
        end
    end

    assign {bus.RegWrite_EX, bus.MemtoReg_EX, bus.Branch_EX, bus.MemRead_EX,
            bus.MemWrite_EX, bus.RegDst_EX, bus.ALUSrc_EX, bus.ALUOp_EX} = r_ctrl;
    assign bus.Valid_EX         = r_valid;
    assign bus.PCAddResult_EX   = r_pcAdd;
    assign bus.ReadData1_EX     = r_readData1;
    assign bus.ReadData2_EX     = r_readData2;
    assign bus.SignExtResult_EX = r_signExt;
    assign bus.rs_EX            = r_rs;
    assign bus.rt_EX            = r_rt;
    assign bus.rd_EX            = r_rd;
    assign bus.BubbleCount      = r_bubbleCount;

    assign bus.PCWrite   = (w_act == ACT_NORMAL) || (w_act == ACT_FLUSH);
    assign bus.IFIDWrite = bus.PCWrite;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_issue
// Purpose  : Self-checking bench for id_ex_issue against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_issue;
    import id_ex_issue_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    id_ex_issue_if #(.CNT_W(16)) bus ();
    id_ex_issue_if #(.CNT_W(2))  busSat ();

    id_ex_issue #(.CNT_W(16)) dut    (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
    id_ex_issue #(.CNT_W(2))  dutSat (.Clk(Clk), .Reset_n(Reset_n), .bus(busSat.slave));

    // The narrow-counter copy sees identical stimulus.
    assign busSat.RegWrite_ID      = bus.RegWrite_ID;
    assign busSat.MemtoReg_ID      = bus.MemtoReg_ID;
    assign busSat.Branch_ID        = bus.Branch_ID;
    assign busSat.MemRead_ID       = bus.MemRead_ID;
    assign busSat.MemWrite_ID      = bus.MemWrite_ID;
    assign busSat.RegDst_ID        = bus.RegDst_ID;
    assign busSat.ALUSrc_ID        = bus.ALUSrc_ID;
    assign busSat.ALUOp_ID         = bus.ALUOp_ID;
    assign busSat.PCAddResult_ID   = bus.PCAddResult_ID;
    assign busSat.ReadData1_ID     = bus.ReadData1_ID;
    assign busSat.ReadData2_ID     = bus.ReadData2_ID;
    assign busSat.SignExtResult_ID = bus.SignExtResult_ID;
    assign busSat.rs_ID            = bus.rs_ID;
    assign busSat.rt_ID            = bus.rt_ID;
    assign busSat.rd_ID            = bus.rd_ID;
    assign busSat.Valid_ID         = bus.Valid_ID;
    assign busSat.Flush_MEM        = bus.Flush_MEM;
    assign busSat.Hold_MEM         = bus.Hold_MEM;

    // ctl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc}
    typedef struct packed {
        bit [6:0]  ctl;
        bit [5:0]  aluOp;
        bit [31:0] pc, r1, r2, se;
        bit [4:0]  rs, rt, rd;
        bit        valid;
    } slot_t;

    slot_t       m;
    int unsigned mBubbles;
    bit          mKnown = 1'b0;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic slot_t issueSlot();
        slot_t s;
        s.valid = bus.Valid_ID;
        s.ctl   = bus.Valid_ID ? {bus.RegWrite_ID, bus.MemtoReg_ID, bus.Branch_ID, bus.MemRead_ID,
                                  bus.MemWrite_ID, bus.RegDst_ID, bus.ALUSrc_ID} : 7'b0;
        s.aluOp = bus.Valid_ID ? bus.ALUOp_ID : 6'b0;
        s.pc    = bus.PCAddResult_ID;
        s.r1    = bus.ReadData1_ID;
        s.r2    = bus.ReadData2_ID;
        s.se    = bus.SignExtResult_ID;
        s.rs    = bus.rs_ID;
        s.rt    = bus.rt_ID;
        s.rd    = bus.rd_ID;
        return s;
    endfunction

    function automatic slot_t killed(input slot_t s);
        slot_t k = s;
        k.valid = 1'b0;
        k.ctl   = 7'b0;
        k.aluOp = 6'b0;
        return k;
    endfunction

    function automatic bit modelLU();
        return m.valid && m.ctl[3] && bus.Valid_ID && (m.rt != 0) &&
               ((m.rt == bus.rs_ID) || (m.rt == bus.rt_ID));
    endfunction

    function automatic int unsigned clampTo(input int unsigned v, input int unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge Clk) begin
        if (!Reset_n) begin
            m        <= '0;
            mBubbles <= 0;
            mKnown   <= 1'b1;
        end else if (mKnown) begin
            if (bus.Flush_MEM) begin
                m        <= killed(issueSlot());
                mBubbles <= mBubbles + 1;
            end else if (bus.Hold_MEM) begin
                m <= m;
            end else if (modelLU()) begin
                m        <= killed(m);
                mBubbles <= mBubbles + 1;
            end else begin
                m <= issueSlot();
            end
        end
    end

    always @(negedge Clk) begin
        if (mKnown) begin
            bit expWrite;
            expWrite = bus.Flush_MEM || (!bus.Hold_MEM && !modelLU());
            check("ctl", {bus.RegWrite_EX, bus.MemtoReg_EX, bus.Branch_EX, bus.MemRead_EX,
                          bus.MemWrite_EX, bus.RegDst_EX, bus.ALUSrc_EX}, m.ctl);
            check("aluop", bus.ALUOp_EX, m.aluOp);
            check("data", {bus.PCAddResult_EX, bus.ReadData1_EX, bus.ReadData2_EX,
                           bus.SignExtResult_EX}, {m.pc, m.r1, m.r2, m.se});
            check("regs", {bus.rs_EX, bus.rt_EX, bus.rd_EX}, {m.rs, m.rt, m.rd});
            check("valid", bus.Valid_EX, m.valid);
            check("pcwrite", bus.PCWrite, expWrite);
            check("ifidwrite", bus.IFIDWrite, expWrite);
            check("count", bus.BubbleCount, clampTo(mBubbles, 65535));
            check("countsat", busSat.BubbleCount, clampTo(mBubbles, 3));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setInstr(input bit valid, input bit regWrite, input bit memRead,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] r1);
        bus.Valid_ID = valid;      bus.RegWrite_ID = regWrite; bus.MemRead_ID = memRead;
        bus.MemtoReg_ID = memRead; bus.Branch_ID = 1'b0;       bus.MemWrite_ID = 1'b0;
        bus.RegDst_ID = !memRead;  bus.ALUSrc_ID = memRead;    bus.ALUOp_ID = 6'h21;
        bus.PCAddResult_ID = 32'h0000_0100; bus.ReadData1_ID = r1;
        bus.ReadData2_ID = 32'h0000_0077;   bus.SignExtResult_ID = 32'h0000_0004;
        bus.rs_ID = rs; bus.rt_ID = rt; bus.rd_ID = rd;
    endtask

    task automatic randomId();
        bus.Valid_ID    = ($urandom % 5) != 0;
        bus.RegWrite_ID = $urandom % 2;  bus.MemtoReg_ID = $urandom % 2;
        bus.Branch_ID   = $urandom % 2;  bus.MemRead_ID  = $urandom % 2;
        bus.MemWrite_ID = $urandom % 2;  bus.RegDst_ID   = $urandom % 2;
        bus.ALUSrc_ID   = $urandom % 2;  bus.ALUOp_ID    = 6'($urandom);
        bus.PCAddResult_ID = $urandom;   bus.ReadData1_ID = $urandom;
        bus.ReadData2_ID   = $urandom;   bus.SignExtResult_ID = $urandom;
        bus.rs_ID = 5'($urandom % 4); bus.rt_ID = 5'($urandom % 4); bus.rd_ID = 5'($urandom % 4);
    endtask

    initial begin
        bus.Flush_MEM = 1'b0;
        bus.Hold_MEM  = 1'b0;
        Reset_n       = 1'b0;
        setInstr(1, 1, 1, 5'd7, 5'd9, 5'd3, 32'hDEAD_BEEF);

        // Reset with nonzero ID
        repeat (2) tick();
        check("rst_valid", bus.Valid_EX, 1'b0);
        check("rst_rd1", bus.ReadData1_EX, 32'h0);
        check("rst_regwrite", bus.RegWrite_EX, 1'b0);
        check("rst_count", bus.BubbleCount, 16'd0);
        Reset_n = 1'b1;

        // Plain pass-through
        setInstr(1, 1, 0, 5'd1, 5'd2, 5'd5, 32'h0000_1234);
        tick();
        check("pass_rd1", bus.ReadData1_EX, 32'h0000_1234);
        check("pass_rd", bus.rd_EX, 5'd5);
        check("pass_regwrite", bus.RegWrite_EX, 1'b1);
        check("pass_pcwrite", bus.PCWrite, 1'b1);

        // Load-use: lw rt=8 then add rs=8
        setInstr(1, 1, 1, 5'd3, 5'd8, 5'd0, 32'h0);
        tick();
        setInstr(1, 1, 0, 5'd8, 5'd9, 5'd10, 32'h0000_0011);
        #1;
        check("lu_pcwrite", bus.PCWrite, 1'b0);
        check("lu_ifidwrite", bus.IFIDWrite, 1'b0);
        tick();
        check("lu_valid", bus.Valid_EX, 1'b0);
        check("lu_memread", bus.MemRead_EX, 1'b0);
        check("lu_regwrite", bus.RegWrite_EX, 1'b0);
        check("lu_count", bus.BubbleCount, 16'd1);
        check("lu_release", bus.PCWrite, 1'b1);
        tick();
        check("lu_issue_valid", bus.Valid_EX, 1'b1);
        check("lu_issue_rs", bus.rs_EX, 5'd8);
        check("lu_issue_rd", bus.rd_EX, 5'd10);

        // Zero-register guard
        setInstr(1, 1, 1, 5'd0, 5'd0, 5'd0, 32'h0);
        tick();
        setInstr(1, 1, 0, 5'd0, 5'd0, 5'd4, 32'h0);
        #1;
        check("zero_pcwrite", bus.PCWrite, 1'b1);
        tick();
        check("zero_valid", bus.Valid_EX, 1'b1);
        check("zero_count", bus.BubbleCount, 16'd1);

        // Flush beats load-use
        setInstr(1, 1, 1, 5'd3, 5'd8, 5'd0, 32'h0);
        tick();
        setInstr(1, 1, 0, 5'd8, 5'd9, 5'd10, 32'h0);
        bus.Flush_MEM = 1'b1;
        #1;
        check("flush_pcwrite", bus.PCWrite, 1'b1);
        tick();
        bus.Flush_MEM = 1'b0;
        setInstr(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
        check("flush_valid", bus.Valid_EX, 1'b0);
        check("flush_count", bus.BubbleCount, 16'd2);

        // Hold freezes EX for three cycles
        setInstr(1, 1, 0, 5'd1, 5'd2, 5'd3, 32'h0000_ABCD);
        tick();
        bus.Hold_MEM = 1'b1;
        setInstr(1, 0, 0, 5'd4, 5'd5, 5'd6, 32'h0000_5555);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_pcwrite", bus.PCWrite, 1'b0);
            tick();
            check("hold_rd1", bus.ReadData1_EX, 32'h0000_ABCD);
        end
        bus.Hold_MEM = 1'b0;

        // Saturation of the 2-bit counter
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        bus.Flush_MEM = 1'b1;
        repeat (5) tick();
        bus.Flush_MEM = 1'b0;
        check("sat_count2", busSat.BubbleCount, 2'd3);
        check("sat_count16", bus.BubbleCount, 16'd5);

        // Randomized phase
        for (int c = 0; c < 2000; c++) begin
            Reset_n       = ($urandom % 40) != 0;
            bus.Flush_MEM = ($urandom % 10) == 0;
            bus.Hold_MEM  = ($urandom % 7) == 0;
            randomId();
            tick();
        end

        @(negedge Clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
